// File: rtl/idu_pipe.sv
// RV32I/RV32E decode stage: classifies a fetched instruction, builds its immediate and
// register fields, stalls on RAW/WAW hazards and presents the result in a one-entry output register.
module idu_pipe #(
    parameter int XLEN   = 32,
    parameter int NR_REG = 32,
    parameter int AW     = $clog2(NR_REG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [15:0]     out_inst_type,
    output logic [2:0]      out_funct3,
    output logic            out_funct7b5,
    output logic [XLEN-1:0] out_imm,
    output logic [AW-1:0]   out_rs1,
    output logic [AW-1:0]   out_rs2,
    output logic [AW-1:0]   out_rd,
    output logic            out_rd_wen,
    output logic            out_illegal,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd
);

    logic [6:0]        opcode;
    logic [2:0]        f3;
    logic [6:0]        f7;
    logic [4:0]        rs1_f, rs2_f, rd_f;
    logic [10:0]       cls;
    logic              use_rs1, use_rs2, use_rd;
    logic              range_bad, dec_legal;
    logic [31:0]       imm32;
    logic [15:0]       dec_type;
    logic [XLEN-1:0]   dec_imm;
    logic [AW-1:0]     dec_rs1, dec_rs2, dec_rd;
    logic              dec_wen;
    logic [NR_REG-1:0] pending, blocked;
    logic              hazard, accept, fire;

    assign opcode = in_inst[6:0];
    assign f3     = in_inst[14:12];
    assign f7     = in_inst[31:25];
    assign rs1_f  = in_inst[19:15];
    assign rs2_f  = in_inst[24:20];
    assign rd_f   = in_inst[11:7];

    // cls bit order matches out_inst_type bits 0..10
    always_comb begin
        cls = '0;
        case (opcode)
            7'b0110111: cls[0] = 1'b1;
            7'b0010111: cls[1] = 1'b1;
            7'b1101111: cls[2] = 1'b1;
            7'b1100111: cls[3] = (f3 == 3'b000);
            7'b1100011: cls[4] = (f3 != 3'b010) && (f3 != 3'b011);
            7'b0000011: cls[5] = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                                 (f3 == 3'b100) || (f3 == 3'b101);
            7'b0100011: cls[6] = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
            7'b0010011: begin
                case (f3)
                    3'b001:  cls[7] = (f7 == 7'b0000000);
                    3'b101:  cls[7] = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                    default: cls[7] = 1'b1;
                endcase
            end
            7'b0110011: cls[8] = (f7 == 7'b0000000) ||
                                 ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
            default: ;
        endcase
        cls[9]  = (in_inst == 32'h0010_0073);
        cls[10] = (in_inst == 32'h0000_0073);
    end

    assign use_rs1 = cls[3] | cls[4] | cls[5] | cls[6] | cls[7] | cls[8];
    assign use_rs2 = cls[4] | cls[6] | cls[8];
    assign use_rd  = cls[0] | cls[1] | cls[2] | cls[3] | cls[5] | cls[7] | cls[8];

    assign range_bad = (use_rs1 && ({1'b0, rs1_f} >= 6'(NR_REG))) ||
                       (use_rs2 && ({1'b0, rs2_f} >= 6'(NR_REG))) ||
                       (use_rd  && ({1'b0, rd_f}  >= 6'(NR_REG)));
    assign dec_legal = (cls != '0) && !range_bad;

    always_comb begin
        imm32 = '0;
        if (cls[3] || cls[5] || cls[7])
            imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
        else if (cls[6])
            imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
        else if (cls[4])
            imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
        else if (cls[0] || cls[1])
            imm32 = {in_inst[31:12], 12'b0};
        else if (cls[2])
            imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
    end

    assign dec_type = dec_legal ? {5'b0, cls} : '0;
    assign dec_imm  = dec_legal ? XLEN'($signed(imm32)) : '0;
    assign dec_rs1  = (dec_legal && use_rs1) ? rs1_f[AW-1:0] : '0;
    assign dec_rs2  = (dec_legal && use_rs2) ? rs2_f[AW-1:0] : '0;
    assign dec_rd   = (dec_legal && use_rd)  ? rd_f[AW-1:0]  : '0;
    assign dec_wen  = dec_legal && use_rd && (rd_f != 5'd0);

    // A register is blocked if still pending (unless retiring this cycle) or owned by the held entry
    always_comb begin
        blocked = pending;
        if (wb_valid)
            blocked[wb_rd] = 1'b0;
        if (out_valid && out_rd_wen)
            blocked[out_rd] = 1'b1;
        blocked[0] = 1'b0;
    end

    assign hazard   = blocked[dec_rs1] | blocked[dec_rs2] | blocked[dec_rd];
    assign in_ready = (~out_valid | out_ready) & ~hazard & ~flush;
    assign accept   = in_valid & in_ready;
    assign fire     = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid     <= 1'b0;
            out_pc        <= '0;
            out_inst_type <= '0;
            out_funct3    <= '0;
            out_funct7b5  <= 1'b0;
            out_imm       <= '0;
            out_rs1       <= '0;
            out_rs2       <= '0;
            out_rd        <= '0;
            out_rd_wen    <= 1'b0;
            out_illegal   <= 1'b0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            out_pc        <= in_pc;
            out_inst_type <= dec_type;
            out_funct3    <= f3;
            out_funct7b5  <= in_inst[30];
            out_imm       <= dec_imm;
            out_rs1       <= dec_rs1;
            out_rs2       <= dec_rs2;
            out_rd        <= dec_rd;
            out_rd_wen    <= dec_wen;
            out_illegal   <= !dec_legal;
        end else if (fire || flush) begin
            out_valid     <= 1'b0;
        end
    end

    // Issue sets take priority over a same-cycle writeback to the same register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
        end else begin
            for (int i = 1; i < NR_REG; i++) begin
                if (fire && out_rd_wen && (out_rd == AW'(i)))
                    pending[i] <= 1'b1;
                else if (wb_valid && (wb_rd == AW'(i)))
                    pending[i] <= 1'b0;
            end
            pending[0] <= 1'b0;
        end
    end

endmodule

// File: tb/tb_idu_pipe.sv
// Directed bench for idu_pipe: a decode vector table plus hand-written hazard,
// back-pressure, flush and reset sequences, with an RV32E instance for range checks.
module tb_idu_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_inst, in_pc, out_pc, out_imm;
    logic [15:0] out_inst_type;
    logic [2:0]  out_funct3;
    logic        out_funct7b5, out_rd_wen, out_illegal, wb_valid;
    logic [4:0]  out_rs1, out_rs2, out_rd, wb_rd;

    logic        e_flush, e_in_valid, e_in_ready, e_out_valid, e_out_ready;
    logic [31:0] e_in_inst, e_in_pc, e_out_pc, e_out_imm;
    logic [15:0] e_out_inst_type;
    logic [2:0]  e_out_funct3;
    logic        e_out_funct7b5, e_out_rd_wen, e_out_illegal, e_wb_valid;
    logic [3:0]  e_out_rs1, e_out_rs2, e_out_rd, e_wb_rd;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [15:0] typ;
        logic [31:0] imm;
        logic [4:0]  rs1, rs2, rd;
        logic        wen, ill;
    } vec_t;

    vec_t vecs[$];
    vec_t evecs[$];

    always #5 clk = ~clk;

    idu_pipe #(.XLEN(32), .NR_REG(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_inst_type(out_inst_type), .out_funct3(out_funct3), .out_funct7b5(out_funct7b5),
        .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_rd_wen(out_rd_wen), .out_illegal(out_illegal),
        .wb_valid(wb_valid), .wb_rd(wb_rd)
    );

    idu_pipe #(.XLEN(32), .NR_REG(16)) dut_e (
        .clk(clk), .rst(rst), .flush(e_flush),
        .in_valid(e_in_valid), .in_ready(e_in_ready), .in_inst(e_in_inst), .in_pc(e_in_pc),
        .out_valid(e_out_valid), .out_ready(e_out_ready), .out_pc(e_out_pc),
        .out_inst_type(e_out_inst_type), .out_funct3(e_out_funct3), .out_funct7b5(e_out_funct7b5),
        .out_imm(e_out_imm), .out_rs1(e_out_rs1), .out_rs2(e_out_rs2), .out_rd(e_out_rd),
        .out_rd_wen(e_out_rd_wen), .out_illegal(e_out_illegal),
        .wb_valid(e_wb_valid), .wb_rd(e_wb_rd)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void add_vec(ref vec_t q[$], input string name, input logic [31:0] inst,
                                    input logic [15:0] typ, input logic [31:0] imm,
                                    input logic [4:0] rs1, input logic [4:0] rs2,
                                    input logic [4:0] rd, input logic wen, input logic ill);
        vec_t v;
        v.name = name; v.inst = inst; v.typ = typ; v.imm = imm;
        v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.wen = wen; v.ill = ill;
        q.push_back(v);
    endfunction

    task automatic apply_stimulus(input logic [31:0] inst, input logic [31:0] pc);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
    endtask

    // Looks at in_ready for one instruction without letting it be accepted
    task automatic probe(input string name, input logic [31:0] inst, input logic exp_ready);
        in_valid = 1'b1;
        in_inst  = inst;
        #1;
        check(name, 32'(in_ready), 32'(exp_ready));
        in_valid = 1'b0;
    endtask

    task automatic check_output(input vec_t v, input logic [31:0] pc);
        check({v.name, " valid"},   32'(out_valid), 32'd1);
        check({v.name, " type"},    32'(out_inst_type), 32'(v.typ));
        check({v.name, " imm"},     out_imm, v.imm);
        check({v.name, " rs1"},     32'(out_rs1), 32'(v.rs1));
        check({v.name, " rs2"},     32'(out_rs2), 32'(v.rs2));
        check({v.name, " rd"},      32'(out_rd), 32'(v.rd));
        check({v.name, " wen"},     32'(out_rd_wen), 32'(v.wen));
        check({v.name, " illegal"}, 32'(out_illegal), 32'(v.ill));
        check({v.name, " pc"},      out_pc, pc);
    endtask

    task automatic wb_pulse(input logic [4:0] r);
        @(negedge clk);
        wb_valid = 1'b1;
        wb_rd    = r;
        @(negedge clk);
        wb_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0;
        out_ready = 1'b1; wb_valid = 1'b0; wb_rd = '0;
        e_flush = 1'b0; e_in_valid = 1'b0; e_in_inst = '0; e_in_pc = '0;
        e_out_ready = 1'b1; e_wb_valid = 1'b0; e_wb_rd = '0;

        add_vec(vecs, "addi",      32'h0050_0093, 16'h0080, 32'h0000_0005, 0, 0, 1, 1, 0);
        add_vec(vecs, "beq",       32'hFE00_0EE3, 16'h0010, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
        add_vec(vecs, "ebreak",    32'h0010_0073, 16'h0200, 32'h0,         0, 0, 0, 0, 0);
        add_vec(vecs, "ecall",     32'h0000_0073, 16'h0400, 32'h0,         0, 0, 0, 0, 0);
        add_vec(vecs, "all_ones",  32'hFFFF_FFFF, 16'h0000, 32'h0,         0, 0, 0, 0, 1);
        add_vec(vecs, "lui",       32'h1234_52B7, 16'h0001, 32'h1234_5000, 0, 0, 5, 1, 0);
        add_vec(vecs, "auipc",     32'hFFFF_F197, 16'h0002, 32'hFFFF_F000, 0, 0, 3, 1, 0);
        add_vec(vecs, "jal",       32'hFF9F_F0EF, 16'h0004, 32'hFFFF_FFF8, 0, 0, 1, 1, 0);
        add_vec(vecs, "jalr",      32'h0040_8067, 16'h0008, 32'h0000_0004, 1, 0, 0, 0, 0);
        add_vec(vecs, "lw",        32'hFF41_2303, 16'h0020, 32'hFFFF_FFF4, 2, 0, 6, 1, 0);
        add_vec(vecs, "sw",        32'h0071_A423, 16'h0040, 32'h0000_0008, 3, 7, 0, 0, 0);
        add_vec(vecs, "sub",       32'h4062_8233, 16'h0100, 32'h0,         5, 6, 4, 1, 0);
        add_vec(vecs, "op_bad_f7", 32'h4062_A233, 16'h0000, 32'h0,         0, 0, 0, 0, 1);
        add_vec(vecs, "srai",      32'h4030_D093, 16'h0080, 32'h0000_0403, 1, 0, 1, 1, 0);
        add_vec(vecs, "slli_bad",  32'h4030_9093, 16'h0000, 32'h0,         0, 0, 0, 0, 1);
        add_vec(vecs, "br_f3_010", 32'h0000_2063, 16'h0000, 32'h0,         0, 0, 0, 0, 1);
        add_vec(vecs, "jalr_f3",   32'h0040_9067, 16'h0000, 32'h0,         0, 0, 0, 0, 1);

        add_vec(evecs, "e_addi_x16", 32'h0010_0813, 16'h0000, 32'h0,       0, 0, 0, 0, 1);
        add_vec(evecs, "e_addi_x15", 32'h0010_0793, 16'h0080, 32'h1,       0, 0, 15, 1, 0);
        add_vec(evecs, "e_add_x17",  32'h0008_80B3, 16'h0000, 32'h0,       0, 0, 0, 0, 1);

        @(negedge clk);
        #1;
        check("reset out_valid",  32'(out_valid), 32'd0);
        check("reset type",       32'(out_inst_type), 32'd0);
        check("reset in_ready",   32'(in_ready), 32'd1);
        check("reset e_out_valid", 32'(e_out_valid), 32'd0);
        rst = 1'b1;

        // Decode table: accept, inspect, hand off, then retire the destination
        foreach (vecs[i]) begin
            @(negedge clk);
            wb_valid = 1'b0;
            apply_stimulus(vecs[i].inst, 32'h1000 + 32'(i) * 4);
            #1;
            check({vecs[i].name, " in_ready"}, 32'(in_ready), 32'd1);
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            check_output(vecs[i], 32'h1000 + 32'(i) * 4);
            @(negedge clk);
            #1;
            check({vecs[i].name, " drained"}, 32'(out_valid), 32'd0);
            wb_valid = 1'b1;
            wb_rd    = vecs[i].rd;
        end
        @(negedge clk);
        wb_valid = 1'b0;

        foreach (evecs[i]) begin
            @(negedge clk);
            e_in_valid = 1'b1;
            e_in_inst  = evecs[i].inst;
            e_in_pc    = 32'h40;
            @(negedge clk);
            e_in_valid = 1'b0;
            #1;
            check({evecs[i].name, " valid"},   32'(e_out_valid), 32'd1);
            check({evecs[i].name, " type"},    32'(e_out_inst_type), 32'(evecs[i].typ));
            check({evecs[i].name, " illegal"}, 32'(e_out_illegal), 32'(evecs[i].ill));
            check({evecs[i].name, " wen"},     32'(e_out_rd_wen), 32'(evecs[i].wen));
            check({evecs[i].name, " rd"},      32'(e_out_rd), 32'(evecs[i].rd));
            check({evecs[i].name, " imm"},     e_out_imm, evecs[i].imm);
        end

        // RAW stall on x1 released by a same-cycle writeback
        @(negedge clk);
        apply_stimulus(32'h0050_0093, 32'h100);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("seq1 addi rd", 32'(out_rd), 32'd1);
        @(negedge clk);
        apply_stimulus(32'h0010_8133, 32'h104);
        #1;
        check("seq2 raw stall a", 32'(in_ready), 32'd0);
        @(negedge clk);
        #1;
        check("seq2 raw stall b", 32'(in_ready), 32'd0);
        wb_valid = 1'b1;
        wb_rd    = 5'd1;
        #1;
        check("seq2 wb bypass", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        wb_valid = 1'b0;
        #1;
        check("seq2 add type", 32'(out_inst_type), 32'h0100);
        check("seq2 add rs1",  32'(out_rs1), 32'd1);
        check("seq2 add rs2",  32'(out_rs2), 32'd1);
        check("seq2 add rd",   32'(out_rd), 32'd2);
        wb_pulse(5'd2);

        // Back-pressure: second instruction waits, held entry stays put
        out_ready = 1'b0;
        @(negedge clk);
        apply_stimulus(32'h0010_0193, 32'h200);
        @(negedge clk);
        apply_stimulus(32'h0020_0213, 32'h204);
        #1;
        check("seq3 blocked", 32'(in_ready), 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            check("seq3 hold valid", 32'(out_valid), 32'd1);
            check("seq3 hold rd",    32'(out_rd), 32'd3);
            check("seq3 hold imm",   out_imm, 32'd1);
            check("seq3 hold pc",    out_pc, 32'h200);
            check("seq3 hold ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("seq3 release", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("seq3 second valid", 32'(out_valid), 32'd1);
        check("seq3 second rd",    32'(out_rd), 32'd4);
        check("seq3 second imm",   out_imm, 32'd2);
        check("seq3 second pc",    out_pc, 32'h204);
        wb_pulse(5'd3);
        wb_pulse(5'd4);

        // Dependence on the held entry, then on its pending write
        out_ready = 1'b0;
        @(negedge clk);
        apply_stimulus(32'h0010_0193, 32'h300);
        @(negedge clk);
        out_ready = 1'b1;
        apply_stimulus(32'h0011_8313, 32'h304);
        #1;
        check("seq3b held hazard", 32'(in_ready), 32'd0);
        @(negedge clk);
        #1;
        check("seq3b pending hazard", 32'(in_ready), 32'd0);
        check("seq3b drained",        32'(out_valid), 32'd0);
        wb_valid = 1'b1;
        wb_rd    = 5'd3;
        #1;
        check("seq3b bypass", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        wb_valid = 1'b0;
        #1;
        check("seq3b rs1", 32'(out_rs1), 32'd3);
        check("seq3b rd",  32'(out_rd), 32'd6);
        wb_pulse(5'd6);

        // Flush of a held entry leaves no pending write behind
        out_ready = 1'b0;
        @(negedge clk);
        apply_stimulus(32'h0050_0093, 32'h400);
        @(negedge clk);
        apply_stimulus(32'h0020_0213, 32'h404);
        flush = 1'b1;
        #1;
        check("seq6 flush valid before", 32'(out_valid), 32'd1);
        check("seq6 flush in_ready",     32'(in_ready), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        check("seq6 flushed", 32'(out_valid), 32'd0);
        probe("seq6 no set after flush", 32'h0010_8133, 1'b1);

        // Flush together with out_ready: the handshake still sets pending
        out_ready = 1'b1;
        @(negedge clk);
        apply_stimulus(32'h0050_0093, 32'h500);
        @(negedge clk);
        apply_stimulus(32'h0020_0213, 32'h504);
        flush = 1'b1;
        #1;
        check("seq6b flush blocks", 32'(in_ready), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        check("seq6b flushed", 32'(out_valid), 32'd0);
        probe("seq6b set kept", 32'h0010_8133, 1'b0);

        // Asynchronous reset with x1 pending and an entry held
        out_ready = 1'b0;
        @(negedge clk);
        apply_stimulus(32'h0020_0213, 32'h600);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("seq6c held", 32'(out_valid), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("seq6c async valid", 32'(out_valid), 32'd0);
        check("seq6c async rd",    32'(out_rd), 32'd0);
        check("seq6c async imm",   out_imm, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        probe("seq6c pending cleared", 32'h0010_8133, 1'b1);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
